xy_scan_gen: RTL and testbench
==============================

// Module: xy_scan_gen
// PURPOSE
//  Hardware X/Y scan generator for the downsampling datapath. Owns the X/Y coordinate
//  counters and programmable limits that the flag comparator only observes, and walks a
//  strided raster over the source image. Emits one pixel address per accepted handshake.
//  Flags row_end and frame_end, so the instruction stream needs no software loop compares.
// PARAMETERS
//  COORD_W   16  width of X/Y counters, limits and stride
//  ADDR_W    16  width of generated pixel address; wraps modulo 2**ADDR_W
// PORTS
//  clock      in   1        single clock, all state updates on posedge
//  reset      in   1        synchronous, active-high
//  cfg_wr_en  in   1        config write strobe, sampled on posedge
//  cfg_sel    in   2        0=x_limit 1=y_limit 2=stride 3=row_pitch
//  cfg_data   in   COORD_W  config value
//  start      in   1        1-cycle pulse; starts a scan from (0,0)
//  step_ready in   1        consumer accepts current address
//  addr_valid out  1        addr/x_out/y_out valid
//  addr       out  ADDR_W   row_base + x
//  x_out      out  COORD_W  current X
//  y_out      out  COORD_W  current Y
//  row_end    out  1        valid beat is last of its row
//  frame_end  out  1        valid beat is last of the frame
//  busy       out  1        scan in progress (state != IDLE)
//  done       out  1        1-cycle pulse after final accepted beat
// BEHAVIOUR
//  Reset: all outputs 0; x,y,row_base=0; x_limit=y_limit=0, stride=1, row_pitch=0; state IDLE.
//  Config: writes take effect next cycle in IDLE only; ignored while busy.
//   stride write of 0 stores 1.
//  FSM IDLE->SCAN on start; SCAN->DONE on accept of frame_end beat; DONE->IDLE next cycle.
//  start: x=y=row_base=0.
//   If x_limit==0 or y_limit==0, goes IDLE->DONE directly; no addr_valid beat.
//   Ignored when not IDLE.
//  SCAN: addr_valid=1 combinationally from registered state; outputs hold until accepted.
//  Accept (addr_valid && step_ready), one step per cycle, zero bubbles:
//   nx = x + stride, computed at COORD_W+1 bits so overflow counts as >= limit.
//   nx <  x_limit: x=nx.
//   nx >= x_limit: x=0; y += stride; row_base += row_pitch (mod 2**ADDR_W).
//   Also if y+stride >= y_limit: frame ends.
//  row_end = (x+stride >= x_limit) while valid.
//  frame_end = row_end && (y+stride >= y_limit).
//  Limit compares are strict less-than, matching the flag block's x_reg<x_comp semantics.
//  DONE: done=1, addr_valid=0, busy=1 for exactly one cycle.
//  Reset mid-scan: next cycle IDLE, addr_valid=0, no done pulse.
//   Config registers also return to reset values.
//  Latency: first beat valid 1 cycle after start; done 1 cycle after final accept.
// STRUCTURE
//  Package xy_scan_pkg: state enum (IDLE,SCAN,DONE), CFG_X_LIM/CFG_Y_LIM/CFG_STRIDE/
//   CFG_PITCH select constants, default widths.
//  Sub-module scan_axis_counter, instantiated twice for X and Y:
//   holds count, computes wide next value, returns wrap flag.
//  Top keeps the FSM, config bank and row_base accumulator.
// TESTING
//  1 x_lim=4,y_lim=4,stride=2,pitch=16, ready=1 -> addrs 0,2,16,18.
//    row_end on 2 and 18; frame_end on 18; done 1 cycle later.
//  2 Same config, ready toggled 1,0,0,1,... -> addr/x/y held stable while ready=0.
//    No skipped or duplicated beats.
//  3 x_lim=0, start -> done pulse next cycle, addr_valid never asserted.
//  4 stride write 0, x_lim=3,y_lim=1,pitch=0 -> addrs 0,1,2; cfg write mid-scan has no effect.
//  5 reset asserted on 2nd beat of case 1 -> IDLE next cycle, no done.
//    Restart reproduces case 1 exactly.
//  6 pitch=16'hFFF0, x_lim=1,y_lim=3,stride=1 -> addrs 0,FFF0,FFE0 (wrap); start while busy ignored.

Source files
------------

// File: rtl/xy_scan_pkg.sv
// Shared types and constants for the X/Y scan generator.
package xy_scan_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int ADDR_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] CFG_X_LIM  = 2'd0;
  localparam logic [1:0] CFG_Y_LIM  = 2'd1;
  localparam logic [1:0] CFG_STRIDE = 2'd2;
  localparam logic [1:0] CFG_PITCH  = 2'd3;

endpackage

// File: rtl/scan_axis_counter.sv
// One scan axis: holds the coordinate, forms count+stride one bit wider so an
// overflowing sum still reads as "reached the limit", and wraps to 0 on that flag.
module scan_axis_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         step_i,
  input  logic [W-1:0] stride_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   next_wide;

  // Wide next value and strict less-than limit compare.
  always_comb begin
    next_wide = {1'b0, count_q} + {1'b0, stride_i};
    wrap_o    = (next_wide >= {1'b0, limit_i});
  end

  // Clear has priority over a step; a wrapping step returns to 0.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (step_i) begin
      count_d = wrap_o ? '0 : next_wide[W-1:0];
    end
  end

  // Coordinate register.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/xy_scan_gen.sv
// X/Y raster scan generator: config bank, scan FSM and row base accumulator.
//
// state | meaning
// IDLE  | waiting for start; config writes accepted
// SCAN  | presenting an address beat, advancing on each accept
// DONE  | one-cycle done pulse after the final accepted beat
module xy_scan_gen
  import xy_scan_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_wr_en,
  input  logic [1:0]         cfg_sel,
  input  logic [COORD_W-1:0] cfg_data,
  input  logic               start,
  input  logic               step_ready,
  output logic               addr_valid,
  output logic [ADDR_W-1:0]  addr,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               row_end,
  output logic               frame_end,
  output logic               busy,
  output logic               done
);

  state_e state_q, state_d;

  logic [COORD_W-1:0] x_lim_q, y_lim_q, stride_q, pitch_q;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;

  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic               x_wrap, y_wrap;
  logic               start_go, accept;

  // Config bank: writable only in IDLE; a zero stride would stall the scan, so store 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_lim_q  <= '0;
      y_lim_q  <= '0;
      stride_q <= {{(COORD_W-1){1'b0}}, 1'b1};
      pitch_q  <= '0;
    end else if (cfg_wr_en && (state_q == IDLE)) begin
      case (cfg_sel)
        CFG_X_LIM:  x_lim_q  <= cfg_data;
        CFG_Y_LIM:  y_lim_q  <= cfg_data;
        CFG_STRIDE: stride_q <= (cfg_data == '0) ? {{(COORD_W-1){1'b0}}, 1'b1} : cfg_data;
        default:    pitch_q  <= cfg_data;
      endcase
    end
  end

  // Next state and beat outputs, all derived from registered state.
  always_comb begin
    state_d    = state_q;
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = ((x_lim_q == '0) || (y_lim_q == '0)) ? DONE : SCAN;
        end
      end
      SCAN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        if (step_ready && x_wrap && y_wrap) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = addr_valid && step_ready;
  assign row_end   = addr_valid && x_wrap;
  assign frame_end = row_end && y_wrap;

  scan_axis_counter #(.W(COORD_W)) u_x_axis (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (start_go),
    .step_i   (accept),
    .stride_i (stride_q),
    .limit_i  (x_lim_q),
    .count_o  (x_cnt),
    .wrap_o   (x_wrap)
  );

  scan_axis_counter #(.W(COORD_W)) u_y_axis (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (start_go),
    .step_i   (accept && x_wrap),
    .stride_i (stride_q),
    .limit_i  (y_lim_q),
    .count_o  (y_cnt),
    .wrap_o   (y_wrap)
  );

  // Row base advances by the pitch whenever X wraps; address arithmetic wraps naturally.
  always_comb begin
    row_base_d = row_base_q;
    if (start_go) begin
      row_base_d = '0;
    end else if (accept && x_wrap) begin
      row_base_d = row_base_q + ADDR_W'(pitch_q);
    end
  end

  // State and row base registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      row_base_q <= row_base_d;
    end
  end

  assign addr  = row_base_q + ADDR_W'(x_cnt);
  assign x_out = x_cnt;
  assign y_out = y_cnt;

endmodule

// File: tb/tb_xy_scan_gen.sv
// Directed bench for xy_scan_gen: each scenario task drives stimulus and checks inline.
module tb_xy_scan_gen;
  import xy_scan_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [15:0] cfg_data = 16'd0;
  logic        start = 1'b0;
  logic        step_ready = 1'b0;
  logic        addr_valid;
  logic [15:0] addr, x_out, y_out;
  logic        row_end, frame_end, busy, done;

  int checks = 0;
  int failures = 0;

  // Capture results
  logic [15:0] a_addr[$], a_x[$], a_y[$];
  logic        a_re[$], a_fe[$];
  logic [47:0] v_beat[$];
  logic        v_rdy[$];
  int          done_cnt, done_gap, valid_cnt;
  bit          timed_out;

  xy_scan_gen #(.COORD_W(16), .ADDR_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .start      (start),
    .step_ready (step_ready),
    .addr_valid (addr_valid),
    .addr       (addr),
    .x_out      (x_out),
    .y_out      (y_out),
    .row_end    (row_end),
    .frame_end  (frame_end),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  function automatic logic [49:0] beat(input logic [15:0] a, input logic [15:0] x,
                                       input logic [15:0] y, input logic re, input logic fe);
    return {a, x, y, re, fe};
  endfunction

  task automatic write_cfg(input logic [1:0] sel, input logic [15:0] data);
    cfg_wr_en = 1'b1;
    cfg_sel   = sel;
    cfg_data  = data;
    @(negedge clock);
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Records beats until the block goes idle. mid_action at cycle 1:
  // 1 = config write, 2 = start pulse, 3 = reset pulse.
  task automatic capture(input logic [7:0] rdy_pat, input int mid_action, input int budget);
    int last_acc;
    int c;
    last_acc = -100;
    a_addr.delete(); a_x.delete(); a_y.delete(); a_re.delete(); a_fe.delete();
    v_beat.delete(); v_rdy.delete();
    done_cnt = 0; done_gap = -1; valid_cnt = 0; timed_out = 1'b1;
    for (c = 0; c < budget; c++) begin
      if (c == 2) begin
        cfg_wr_en = 1'b0; start = 1'b0; reset = 1'b0;
      end
      if (c == 1) begin
        case (mid_action)
          1: begin cfg_wr_en = 1'b1; cfg_sel = CFG_X_LIM; cfg_data = 16'd10; end
          2: start = 1'b1;
          3: reset = 1'b1;
          default: ;
        endcase
      end
      step_ready = rdy_pat[c % 8];
      #1;
      if (addr_valid) begin
        valid_cnt++;
        v_beat.push_back({addr, x_out, y_out});
        v_rdy.push_back(step_ready);
        if (step_ready) begin
          a_addr.push_back(addr); a_x.push_back(x_out); a_y.push_back(y_out);
          a_re.push_back(row_end); a_fe.push_back(frame_end);
          last_acc = c;
        end
      end
      if (done) begin
        done_cnt++;
        done_gap = c - last_acc;
      end
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clock);
    end
    step_ready = 1'b0;
    cfg_wr_en  = 1'b0;
    start      = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({addr_valid, addr, x_out, y_out, row_end, frame_end, busy, done} !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {addr_valid, addr, x_out, y_out, row_end, frame_end, busy, done});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic cfg_case1();
    write_cfg(CFG_X_LIM, 16'd4);
    write_cfg(CFG_Y_LIM, 16'd4);
    write_cfg(CFG_STRIDE, 16'd2);
    write_cfg(CFG_PITCH, 16'd16);
  endtask

  task automatic check_case1_beats(input string tag);
    logic [49:0] exp_b[4];
    exp_b[0] = beat(16'd0,  16'd0, 16'd0, 1'b0, 1'b0);
    exp_b[1] = beat(16'd2,  16'd2, 16'd0, 1'b1, 1'b0);
    exp_b[2] = beat(16'd16, 16'd0, 16'd2, 1'b0, 1'b0);
    exp_b[3] = beat(16'd18, 16'd2, 16'd2, 1'b1, 1'b1);
    checks++;
    if (timed_out || a_addr.size() != 4) begin
      failures++;
      $display("FAIL %s_beat_count got=%0d timeout=%0d exp=4", tag, a_addr.size(), timed_out);
    end
    for (int i = 0; i < 4 && i < a_addr.size(); i++) begin
      checks++;
      if (beat(a_addr[i], a_x[i], a_y[i], a_re[i], a_fe[i]) !== exp_b[i]) begin
        failures++;
        $display("FAIL %s_beat%0d got=%h exp=%h", tag, i,
                 beat(a_addr[i], a_x[i], a_y[i], a_re[i], a_fe[i]), exp_b[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_gap != 1) begin
      failures++;
      $display("FAIL %s_done got cnt=%0d gap=%0d exp cnt=1 gap=1", tag, done_cnt, done_gap);
    end
  endtask

  task automatic test_basic_scan();
    cfg_case1();
    pulse_start();
    capture(8'hFF, 0, 40);
    check_case1_beats("t1");
  endtask

  task automatic test_backpressure();
    pulse_start();
    capture(8'b1001_1001, 0, 40);
    check_case1_beats("t2");
    checks++;
    if (valid_cnt != 8) begin
      failures++;
      $display("FAIL t2_valid_cycles got=%0d exp=8", valid_cnt);
    end
    for (int i = 1; i < v_beat.size(); i++) begin
      if (!v_rdy[i-1]) begin
        checks++;
        if (v_beat[i] !== v_beat[i-1]) begin
          failures++;
          $display("FAIL t2_hold%0d got=%h exp=%h", i, v_beat[i], v_beat[i-1]);
        end
      end
    end
  endtask

  task automatic test_zero_limit();
    write_cfg(CFG_X_LIM, 16'd0);
    pulse_start();
    capture(8'hFF, 0, 20);
    checks++;
    if (timed_out || valid_cnt != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL t3_zero_limit got valid=%0d done=%0d timeout=%0d exp valid=0 done=1",
               valid_cnt, done_cnt, timed_out);
    end
  endtask

  task automatic check_case4(input string tag);
    logic [49:0] exp_b[3];
    exp_b[0] = beat(16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    exp_b[1] = beat(16'd1, 16'd1, 16'd0, 1'b0, 1'b0);
    exp_b[2] = beat(16'd2, 16'd2, 16'd0, 1'b1, 1'b1);
    checks++;
    if (timed_out || a_addr.size() != 3 || done_cnt != 1) begin
      failures++;
      $display("FAIL %s_count got beats=%0d done=%0d timeout=%0d exp beats=3 done=1",
               tag, a_addr.size(), done_cnt, timed_out);
    end
    for (int i = 0; i < 3 && i < a_addr.size(); i++) begin
      checks++;
      if (beat(a_addr[i], a_x[i], a_y[i], a_re[i], a_fe[i]) !== exp_b[i]) begin
        failures++;
        $display("FAIL %s_beat%0d got=%h exp=%h", tag, i,
                 beat(a_addr[i], a_x[i], a_y[i], a_re[i], a_fe[i]), exp_b[i]);
      end
    end
  endtask

  task automatic test_stride_zero_and_busy_cfg();
    write_cfg(CFG_STRIDE, 16'd0);
    write_cfg(CFG_X_LIM, 16'd3);
    write_cfg(CFG_Y_LIM, 16'd1);
    write_cfg(CFG_PITCH, 16'd0);
    pulse_start();
    capture(8'hFF, 1, 40);
    check_case4("t4a");
    pulse_start();
    capture(8'hFF, 0, 40);
    check_case4("t4b");
  endtask

  task automatic test_reset_midscan();
    cfg_case1();
    pulse_start();
    capture(8'hFF, 3, 40);
    checks++;
    if (timed_out || valid_cnt != 2 || done_cnt != 0 || addr_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t5_reset_abort got valid=%0d done=%0d av=%b busy=%b exp valid=2 done=0 av=0 busy=0",
               valid_cnt, done_cnt, addr_valid, busy);
    end
    // Config must be back at reset values: x_lim=0 gives an immediate done.
    pulse_start();
    capture(8'hFF, 0, 20);
    checks++;
    if (timed_out || valid_cnt != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL t5_cfg_cleared got valid=%0d done=%0d exp valid=0 done=1", valid_cnt, done_cnt);
    end
    cfg_case1();
    pulse_start();
    capture(8'hFF, 0, 40);
    check_case1_beats("t5");
  endtask

  task automatic test_pitch_wrap_and_busy_start();
    logic [49:0] exp_b[3];
    write_cfg(CFG_PITCH, 16'hFFF0);
    write_cfg(CFG_X_LIM, 16'd1);
    write_cfg(CFG_Y_LIM, 16'd3);
    write_cfg(CFG_STRIDE, 16'd1);
    pulse_start();
    capture(8'hFF, 2, 40);
    exp_b[0] = beat(16'h0000, 16'd0, 16'd0, 1'b1, 1'b0);
    exp_b[1] = beat(16'hFFF0, 16'd0, 16'd1, 1'b1, 1'b0);
    exp_b[2] = beat(16'hFFE0, 16'd0, 16'd2, 1'b1, 1'b1);
    checks++;
    if (timed_out || a_addr.size() != 3 || done_cnt != 1 || done_gap != 1) begin
      failures++;
      $display("FAIL t6_count got beats=%0d done=%0d gap=%0d exp beats=3 done=1 gap=1",
               a_addr.size(), done_cnt, done_gap);
    end
    for (int i = 0; i < 3 && i < a_addr.size(); i++) begin
      checks++;
      if (beat(a_addr[i], a_x[i], a_y[i], a_re[i], a_fe[i]) !== exp_b[i]) begin
        failures++;
        $display("FAIL t6_beat%0d got=%h exp=%h", i,
                 beat(a_addr[i], a_x[i], a_y[i], a_re[i], a_fe[i]), exp_b[i]);
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_basic_scan();
    test_backpressure();
    test_zero_limit();
    test_stride_zero_and_busy_cfg();
    test_reset_midscan();
    test_pitch_wrap_and_busy_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
